// File: rtl/dc_wcs.sv
// -----------------------------------------------------------------------------
// dc_wcs -- writable control store for the DC303 control-chip family.
//
// A registered microcode ROM with the AX alias fold, overlaid by NP CAM patch
// slots. A slot that is valid and whose address matches a_in replaces the ROM
// word. A four-state handshake machine loads the slots from the host side.
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   cen      : read clock enable
//   a_in     : microinstruction address (bit AW-1 is the AX line)
//   ma       : registered next-address field
//   mc       : registered opcode field
//   hit      : registered, 1 when ma/mc came from a patch slot
//   ld_req   : patch load request (level)
//   ld_idx   : target patch slot
//   ld_addr  : address to patch
//   ld_data  : replacement word {ma, mc}
//   ld_ack   : load-complete acknowledge, held while ld_req stays high
//   clr      : invalidate all patch slots
// -----------------------------------------------------------------------------
module dc_wcs #(
   parameter int DC303_ROM = 0,
   parameter int AW        = 10,
   parameter int NW        = 9,
   parameter int CW        = 16,
   parameter int NP        = 8,
   parameter int AXFOLD    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cen,
   input  logic [AW-1:0]    a_in,
   output logic [NW-1:0]    ma,
   output logic [CW-1:0]    mc,
   output logic             hit,
   input  logic             ld_req,
   input  logic [3:0]       ld_idx,
   input  logic [AW-1:0]    ld_addr,
   input  logic [NW+CW-1:0] ld_data,
   output logic             ld_ack,
   input  logic             clr
);

   localparam int W  = NW + CW;
   localparam int SW = (NP > 1) ? $clog2(NP) : 1;
   localparam int HW = AW - 5;   // width of the folded index field [AW-2:4]

   typedef enum logic [1:0] {IDLE, INVAL, COMMIT, ACK} state_t;

   // ROM image generator. Image n: ma = index, mc = {index, index} truncated
   // to CW bits and XORed with 16'h5A00 + n.
   function automatic logic [W-1:0] rom_word(input logic [AW-2:0] i);
      logic [NW-1:0] w_ma;
      logic [CW-1:0] w_mc;
      w_ma = NW'(i);
      w_mc = CW'({i, i}) ^ CW'(16'h5A00 + DC303_ROM);
      return {w_ma, w_mc};
   endfunction

   // ---------------------------------------------------------------- ROM index
   logic [AW-2:0] rom_idx;

   // NOTE: every signal written in always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      rom_idx = a_in[AW-2:0];
      // AX alias fold: AX=1 with a_in[6:4]=111 aliases onto the low page.
      if (AXFOLD != 0 && a_in[AW-1] && a_in[6:4] == 3'b111)
         rom_idx[AW-2:4] = HW'(a_in[8:7]);
   end

   // ------------------------------------------------------------ patch match
   logic [NP-1:0] valid;
   logic [AW-1:0] paddr [NP];
   logic [W-1:0]  pdata [NP];
   logic          match_any;
   logic [W-1:0]  match_data;

   // Scan from the top slot down so the lowest matching slot is written last
   // and therefore wins. The compare uses the raw, unfolded address.
   always_comb begin
      match_any  = 1'b0;
      match_data = '0;
      for (int i = NP - 1; i >= 0; i--) begin
         if (valid[i] && paddr[i] == a_in) begin
            match_any  = 1'b1;
            match_data = pdata[i];
         end
      end
   end

   // ------------------------------------------------------------- read stage
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma  <= '0;
         mc  <= '0;
         hit <= 1'b0;
      end else if (cen) begin
         {ma, mc} <= match_any ? match_data : rom_word(rom_idx);
         hit      <= match_any;
      end
   end

   // --------------------------------------------------------------- load FSM
   state_t           state;
   logic [3:0]       cap_idx;
   logic [AW-1:0]    cap_addr;
   logic [W-1:0]     cap_data;
   logic             clr_pend;
   logic             idx_ok;
   logic [SW-1:0]    slot;

   // Out-of-range slot numbers still complete the handshake but write nothing.
   assign idx_ok = ({1'b0, cap_idx} < 5'(NP));
   assign slot   = cap_idx[SW-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cap_idx  <= '0;
         cap_addr <= '0;
         cap_data <= '0;
         clr_pend <= 1'b0;
         valid    <= '0;
         ld_ack   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A clear (fresh or deferred) always runs before a new load.
               if (clr || clr_pend) begin
                  valid    <= '0;
                  clr_pend <= 1'b0;
               end else if (ld_req) begin
                  cap_idx  <= ld_idx;
                  cap_addr <= ld_addr;
                  cap_data <= ld_data;
                  state    <= INVAL;
               end
            end
            INVAL: begin
               if (clr)    clr_pend    <= 1'b1;
               if (idx_ok) valid[slot] <= 1'b0;
               state <= COMMIT;
            end
            COMMIT: begin
               if (clr)    clr_pend    <= 1'b1;
               if (idx_ok) valid[slot] <= 1'b1;
               ld_ack <= 1'b1;
               state  <= ACK;
            end
            ACK: begin
               if (clr) clr_pend <= 1'b1;
               if (!ld_req) begin
                  ld_ack <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: patch storage has no reset; the valid bits alone decide whether a
   // slot can match, so its contents are don't-care until committed.
   always_ff @(posedge clk) begin
      if (state == COMMIT && idx_ok) begin
         paddr[slot] <= cap_addr;
         pdata[slot] <= cap_data;
      end
   end

endmodule
